clk_div_multi: RTL

- Multi-channel programmable clock divider; next generation of the single-channel divider.
- Emits one-cycle enable strobes (tick) and a 50% square-wave level per channel, all in the clkin domain, instead of a gated/derived clock.
- Consumers (light-phase timers, blink generators, debouncers) use tick as a clock enable.
- Divisors are runtime-writable per channel, with glitch-free update at the terminal count.

---
 rtl/clk_div_multi_if.sv | 40 ++++
 rtl/clk_div_multi.sv | 129 ++++++++++++
 2 files changed

// File: rtl/clk_div_multi_if.sv
// -----------------------------------------------------------------------------
// clk_div_multi_if
// Control/status bundle for the multi-channel clock-enable divider.
//
// Signals:
//   ch_en  [NUM_CH]  per-channel run enable (level)
//   wr_en            divisor write strobe, one cycle
//   wr_ch  [CH_W]    target channel of the write
//   wr_div [CNT_W]   new divisor value
//   tick   [NUM_CH]  one-cycle strobe per channel at terminal count
//   wave   [NUM_CH]  square wave per channel, toggles on every tick
//   pend   [NUM_CH]  written divisor waiting for its activation point
//
// Modports:
//   master  drives enables and writes, observes tick/wave/pend
//   slave   the divider itself
// -----------------------------------------------------------------------------
interface clk_div_multi_if #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2,
    parameter int CNT_W  = 32
);
    logic [NUM_CH-1:0] ch_en;
    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [CNT_W-1:0]  wr_div;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] wave;
    logic [NUM_CH-1:0] pend;

    modport master (
        output ch_en, wr_en, wr_ch, wr_div,
        input  tick, wave, pend
    );

    modport slave (
        input  ch_en, wr_en, wr_ch, wr_div,
        output tick, wave, pend
    );
endinterface

// File: rtl/clk_div_multi.sv
// -----------------------------------------------------------------------------
// clk_div_multi
// Multi-channel programmable divider producing clock-enable strobes (tick) and
// 50% square waves (wave), all in the clkin domain. Each channel has its own
// runtime-writable divisor; a written divisor sits in a pending register until
// the channel wraps, is disabled, or is idle (divisor 0), so a running period
// always completes with the divisor it started with.
//
// Ports:
//   clkin   system clock, rising edge
//   rst_n   asynchronous active-low reset
//   sync_n  (only with CLK_DIV_SYNC_EN) active-low synchronous phase realign
//   bus     clk_div_multi_if.slave: ch_en, wr_en/wr_ch/wr_div, tick/wave/pend
//
// Optional feature macro: CLK_DIV_SYNC_EN
//   When defined, sync_n low clears every counter, forces tick and wave to 0
//   and applies any pending divisor; channels restart counting from 0 on the
//   first edge after sync_n returns high.
// -----------------------------------------------------------------------------
module clk_div_multi #(
    parameter int               NUM_CH  = 4,
    parameter int               CH_W    = 2,
    parameter int               CNT_W   = 32,
    parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(50000000)
) (
    input  logic                 clkin,
    input  logic                 rst_n,
`ifdef CLK_DIV_SYNC_EN
    input  logic                 sync_n,
`endif
    clk_div_multi_if.slave       bus
);

    logic              sync_hit;
    logic [NUM_CH-1:0] tick_w;
    logic [NUM_CH-1:0] wave_w;
    logic [NUM_CH-1:0] pend_w;

`ifdef CLK_DIV_SYNC_EN
    assign sync_hit = ~sync_n;
`else
    assign sync_hit = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic [CNT_W-1:0] div_act_q, div_act_d;
            logic [CNT_W-1:0] div_pend_q, div_pend_d;
            logic             pend_q, pend_d;
            logic             tick_q, tick_d;
            logic             wave_q, wave_d;
            logic             wr_hit;
            logic             idle;
            logic             wrap;
            logic             activate;

            // Out-of-range channel numbers never match any gi, so such
            // writes fall through with no effect.
            assign wr_hit   = bus.wr_en && (bus.wr_ch == CH_W'(gi));
            // Divisor 0 is treated exactly like a disabled channel, which
            // also keeps it away from the div_act-1 compare below.
            assign idle     = !bus.ch_en[gi] || (div_act_q == '0);
            assign wrap     = !idle && (cnt_q == div_act_q - CNT_W'(1));
            assign activate = idle || wrap || sync_hit;

            always_comb begin
                cnt_d      = cnt_q;
                div_act_d  = div_act_q;
                div_pend_d = div_pend_q;
                pend_d     = pend_q;
                tick_d     = 1'b0;
                wave_d     = wave_q;

                if (sync_hit) begin
                    cnt_d  = '0;
                    wave_d = 1'b0;
                end else if (idle) begin
                    cnt_d  = '0;
                end else if (wrap) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    wave_d = ~wave_q;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                end

                // A write landing on an activation edge bypasses the pending
                // register and takes effect directly.
                if (activate) begin
                    div_act_d  = wr_hit ? bus.wr_div : div_pend_q;
                    div_pend_d = wr_hit ? bus.wr_div : div_pend_q;
                    pend_d     = 1'b0;
                end else if (wr_hit) begin
                    div_pend_d = bus.wr_div;
                    pend_d     = 1'b1;
                end
            end

            always_ff @(posedge clkin or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q      <= '0;
                    div_act_q  <= DEF_DIV;
                    div_pend_q <= DEF_DIV;
                    pend_q     <= 1'b0;
                    tick_q     <= 1'b0;
                    wave_q     <= 1'b0;
                end else begin
                    cnt_q      <= cnt_d;
                    div_act_q  <= div_act_d;
                    div_pend_q <= div_pend_d;
                    pend_q     <= pend_d;
                    tick_q     <= tick_d;
                    wave_q     <= wave_d;
                end
            end

            assign tick_w[gi] = tick_q;
            assign wave_w[gi] = wave_q;
            assign pend_w[gi] = pend_q;
        end
    endgenerate

    assign bus.tick = tick_w;
    assign bus.wave = wave_w;
    assign bus.pend = pend_w;

endmodule
